axi_rr_arbiter: RTL and testbench
=================================

AXI_RR_ARBITER -- requirements
Module: axi_rr_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_MST, default 3, meaning the number of cache-side masters (2..8).
REQ-002 The module SHALL have parameter LINE_W, default 5, meaning the number of low address bits ignored by the RAW compare.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset; all other ports follow in REQ-004 to REQ-019.
REQ-004 Port: aclk  in  1  sole clock, rising edge.
REQ-005 Port: aresetn  in  1  asynchronous reset, active-low.
REQ-006 Port: m_araddr / m_arlen / m_arsize  in  NUM_MST*32 / NUM_MST*8 / NUM_MST*3  per-master read address, flattened with master i at slice i.
REQ-007 Port: m_arvalid  in  NUM_MST  per-master read request.
REQ-008 Port: m_arready  out  NUM_MST  per-master read address accept.
REQ-009 Port: m_rdata / m_rlast  out  32 / 1  read data and last beat, broadcast to all masters.
REQ-010 Port: m_rvalid  out  NUM_MST  read beat valid, routed to the owning master.
REQ-011 Port: m_rready  in  NUM_MST  per-master read data ready.
REQ-012 Port: m_awaddr / m_awlen / m_awsize / m_awvalid  in  NUM_MST*{32,8,3,1}  per-master write address channel.
REQ-013 Port: m_awready  out  NUM_MST  per-master write address accept.
REQ-014 Port: m_wdata / m_wstrb / m_wlast / m_wvalid  in  NUM_MST*{32,4,1,1}  per-master write data channel.
REQ-015 Port: m_wready  out  NUM_MST  per-master write data accept.
REQ-016 Port: m_bvalid  out  NUM_MST  write response, routed to the owning master; m_bready  in  NUM_MST  per-master response accept.
REQ-017 Port: arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1  AXI3 read address; arready  in  1.
REQ-018 Port: rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI3 read data; rready  out  1.
REQ-019 Port: AXI3 write side  awid..awvalid out (widths as REQ-017), awready in; wid/wdata/wstrb/wlast/wvalid out 4/32/4/1/1, wready in; bid/bresp/bvalid in 4/2/1, bready out.

Function
REQ-020 The read FSM SHALL use states R_IDLE, R_ADDR and R_DATA; the write FSM SHALL use states W_IDLE, W_ADDR, W_DATA and W_RESP; the two SHALL run independently except as stated in REQ-033.
REQ-021 In R_IDLE with any m_arvalid high, the read FSM SHALL grant the first requester searching upward from rd_last+1 modulo NUM_MST, register the grant index, and enter R_ADDR on the next cycle.
REQ-022 In R_ADDR, arvalid SHALL be 1 with the granted master's fields; on arvalid & arready, m_arready[grant] SHALL pulse high for that same cycle only and the FSM SHALL enter R_DATA.
REQ-023 In R_DATA, m_rvalid[grant] SHALL equal rvalid, rready SHALL equal m_rready[grant], and all other m_rvalid bits SHALL be 0.
REQ-024 A beat with rvalid & rready & rlast SHALL return the read FSM to R_IDLE and set rd_last to grant.
REQ-025 The write FSM SHALL apply the same grant rule using wr_last, independent of rd_last.
REQ-026 On awvalid & awready, m_awready[grant] SHALL pulse for one cycle and the write FSM SHALL enter W_DATA.
REQ-027 In W_DATA, the W channel SHALL be a combinational pass-through of the granted master; on wvalid & wready & wlast the FSM SHALL enter W_RESP.
REQ-028 In W_RESP, m_bvalid[grant] SHALL equal bvalid and bready SHALL equal m_bready[grant]; on the bvalid & bready handshake the FSM SHALL return to W_IDLE and set wr_last to grant.
REQ-029 arid, awid and wid SHALL equal the grant index zero-extended to 4 bits; arburst and awburst SHALL be 2'b01; arlock, arcache, arprot and their aw* equivalents SHALL be 0.
REQ-030 A master that deasserts its valid while already granted SHALL NOT cancel the transaction, and the fields registered at grant time SHALL be used.
REQ-031 Requests arriving in the same cycle SHALL be resolved by the round-robin order only; no master SHALL wait for more than NUM_MST-1 other grants.
REQ-032 rresp and bresp SHALL be ignored, and rid and bid SHALL NOT be checked.

Configuration
REQ-033 With ARB_RAW_GUARD_EN defined, an R_IDLE grant SHALL be withheld while the write FSM is not in W_IDLE and the candidate araddr[31:LINE_W] equals the registered awaddr[31:LINE_W]; the read SHALL be granted on the cycle after W_IDLE is reached, and a non-matching candidate SHALL still be granted.
REQ-034 With ARB_RAW_GUARD_EN undefined, no address compare logic SHALL exist and reads SHALL be granted regardless of write state.

Reset
REQ-035 While aresetn=0, both FSMs SHALL be in their IDLE state, rd_last and wr_last SHALL be NUM_MST-1 so master 0 wins first, and all valid/ready outputs (arvalid, awvalid, wvalid, rready, bready, m_*ready, m_rvalid, m_bvalid) SHALL be 0.
REQ-036 Reset asserted mid-burst SHALL abandon the transaction immediately, with no completion signalled to any master.

Verification
REQ-037 Scenario: NUM_MST=3, all m_arvalid held high, 4-beat reads -> grants in order 0,1,2,0 with arid 0,1,2,0.
REQ-038 Scenario: master 1 read, arlen=3, rready toggling every cycle -> exactly 4 m_rvalid[1] handshakes, m_rlast on the 4th, m_rvalid[0]=m_rvalid[2]=0 throughout.
REQ-039 Scenario: read by master 0 and write by master 2 issued concurrently -> both complete with overlapping AR and AW traffic, awid=2.
REQ-040 Scenario (ARB_RAW_GUARD_EN): write 0x1FC0_0020 in flight while a read of 0x1FC0_0034 is pending -> arvalid stays 0 until the cycle after W_IDLE; a read of 0x1FC0_0040 is granted at once.
REQ-041 Scenario: aresetn pulsed low during R_DATA beat 2 -> next cycle arvalid=0, rready=0, and the next grant goes to master 0.

Source files
------------

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter
//   Round-robin arbiter that funnels NUM_MST cache-side masters onto one
//   AXI3 port. Reads and writes have separate FSMs and separate
//   round-robin pointers, so one read and one write can be in flight at once.
//
//   Optional feature (compile-time macro ARB_RAW_GUARD_EN):
//     A read is held back while a write to the same line
//     (address bits [31:LINE_W]) is in flight. Other reads are still granted.
//
//   Ports
//     aclk, aresetn            clock, async active-low reset
//     m_ar* / m_arready        per-master read address (flattened, master i at slice i)
//     m_rdata / m_rlast        read data, broadcast to all masters
//     m_rvalid / m_rready      read beat handshake, routed to the granted master
//     m_aw* / m_awready        per-master write address
//     m_w* / m_wready          per-master write data
//     m_bvalid / m_bready      write response, routed to the granted master
//     ar* r* aw* w* b*         AXI3 slave-side channels
//
//   Handshake semantics: every channel transfers on a rising edge where
//   valid and ready are both high. Valid never depends on ready. A granted
//   master's fields are sampled at grant time; later changes to its valid
//   or address do not affect the transaction already in progress.
//
//   Debug visibility: rd_state and wr_state are named enum signals.
module axi_rr_arbiter #(
  parameter int NUM_MST = 3,
  parameter int LINE_W  = 5
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  // master read side
  input  logic [NUM_MST*32-1:0] m_araddr,
  input  logic [NUM_MST*8-1:0]  m_arlen,
  input  logic [NUM_MST*3-1:0]  m_arsize,
  input  logic [NUM_MST-1:0]    m_arvalid,
  output logic [NUM_MST-1:0]    m_arready,
  output logic [31:0]           m_rdata,
  output logic                  m_rlast,
  output logic [NUM_MST-1:0]    m_rvalid,
  input  logic [NUM_MST-1:0]    m_rready,
  // master write side
  input  logic [NUM_MST*32-1:0] m_awaddr,
  input  logic [NUM_MST*8-1:0]  m_awlen,
  input  logic [NUM_MST*3-1:0]  m_awsize,
  input  logic [NUM_MST-1:0]    m_awvalid,
  output logic [NUM_MST-1:0]    m_awready,
  input  logic [NUM_MST*32-1:0] m_wdata,
  input  logic [NUM_MST*4-1:0]  m_wstrb,
  input  logic [NUM_MST-1:0]    m_wlast,
  input  logic [NUM_MST-1:0]    m_wvalid,
  output logic [NUM_MST-1:0]    m_wready,
  output logic [NUM_MST-1:0]    m_bvalid,
  input  logic [NUM_MST-1:0]    m_bready,
  // AXI3 read address / data
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  // AXI3 write address / data / response
  output logic [3:0]            awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int IW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  rd_state_t rd_state, rd_state_nx;
  wr_state_t wr_state, wr_state_nx;

  logic [IW-1:0] rd_grant, rd_last, rd_pick;
  logic [IW-1:0] wr_grant, wr_last, wr_pick;
  logic [31:0]   rd_addr_q, wr_addr_q;
  logic [7:0]    rd_len_q, wr_len_q;
  logic [2:0]    rd_size_q, wr_size_q;

  logic [NUM_MST-1:0] rd_req;
  logic               rd_done, wr_done;

  // Unpacked views of the flattened master buses.
  logic [31:0] ar_addr_a [NUM_MST];
  logic [7:0]  ar_len_a  [NUM_MST];
  logic [2:0]  ar_size_a [NUM_MST];
  logic [31:0] aw_addr_a [NUM_MST];
  logic [7:0]  aw_len_a  [NUM_MST];
  logic [2:0]  aw_size_a [NUM_MST];
  logic [31:0] w_data_a  [NUM_MST];
  logic [3:0]  w_strb_a  [NUM_MST];

  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      ar_addr_a[i] = m_araddr[i*32 +: 32];
      ar_len_a[i]  = m_arlen[i*8 +: 8];
      ar_size_a[i] = m_arsize[i*3 +: 3];
      aw_addr_a[i] = m_awaddr[i*32 +: 32];
      aw_len_a[i]  = m_awlen[i*8 +: 8];
      aw_size_a[i] = m_awsize[i*3 +: 3];
      w_data_a[i]  = m_wdata[i*32 +: 32];
      w_strb_a[i]  = m_wstrb[i*4 +: 4];
    end
  end

  // First requester strictly after 'last', wrapping at NUM_MST.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_MST-1:0] req,
                                            input logic [IW-1:0]     last);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_MST; i++) begin
      idx = int'(last) + i;
      if (idx >= NUM_MST) idx = idx - NUM_MST;
      if (!found && req[idx[IW-1:0]]) begin
        pick  = idx[IW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef ARB_RAW_GUARD_EN
  // A read to the line of an in-flight write is masked out of arbitration;
  // wr_addr_q holds the write address from grant until W_IDLE is reached.
  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      rd_req[i] = m_arvalid[i] &&
                  !((wr_state != W_IDLE) &&
                    (ar_addr_a[i][31:LINE_W] == wr_addr_q[31:LINE_W]));
    end
  end
`else
  always_comb rd_req = m_arvalid;
`endif

  always_comb begin
    rd_pick = rr_pick(rd_req, rd_last);
    wr_pick = rr_pick(m_awvalid, wr_last);
  end

  assign rd_done = (rd_state == R_DATA) && rvalid && m_rready[rd_grant] && rlast;
  assign wr_done = (wr_state == W_RESP) && bvalid && m_bready[wr_grant];

  // Next-state logic
  always_comb begin
    rd_state_nx = rd_state;
    case (rd_state)
      R_IDLE:  if (|rd_req) rd_state_nx = R_ADDR;
      R_ADDR:  if (arready) rd_state_nx = R_DATA;
      R_DATA:  if (rd_done) rd_state_nx = R_IDLE;
      default: rd_state_nx = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_nx = wr_state;
    case (wr_state)
      W_IDLE:  if (|m_awvalid) wr_state_nx = W_ADDR;
      W_ADDR:  if (awready) wr_state_nx = W_DATA;
      W_DATA:  if (wvalid && wready && wlast) wr_state_nx = W_RESP;
      W_RESP:  if (wr_done) wr_state_nx = W_IDLE;
      default: wr_state_nx = W_IDLE;
    endcase
  end

  // State and grant registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state  <= R_IDLE;
      rd_grant  <= '0;
      rd_last   <= IW'(NUM_MST - 1);
      rd_addr_q <= '0;
      rd_len_q  <= '0;
      rd_size_q <= '0;
    end else begin
      rd_state <= rd_state_nx;
      if (rd_state == R_IDLE && |rd_req) begin
        rd_grant  <= rd_pick;
        rd_addr_q <= ar_addr_a[rd_pick];
        rd_len_q  <= ar_len_a[rd_pick];
        rd_size_q <= ar_size_a[rd_pick];
      end
      if (rd_done) rd_last <= rd_grant;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state  <= W_IDLE;
      wr_grant  <= '0;
      wr_last   <= IW'(NUM_MST - 1);
      wr_addr_q <= '0;
      wr_len_q  <= '0;
      wr_size_q <= '0;
    end else begin
      wr_state <= wr_state_nx;
      if (wr_state == W_IDLE && |m_awvalid) begin
        wr_grant  <= wr_pick;
        wr_addr_q <= aw_addr_a[wr_pick];
        wr_len_q  <= aw_len_a[wr_pick];
        wr_size_q <= aw_size_a[wr_pick];
      end
      if (wr_done) wr_last <= wr_grant;
    end
  end

  // Read-side outputs
  always_comb begin
    arid      = 4'(rd_grant);
    araddr    = rd_addr_q;
    arlen     = rd_len_q;
    arsize    = rd_size_q;
    arburst   = 2'b01;
    arlock    = 2'b00;
    arcache   = 4'b0000;
    arprot    = 3'b000;
    arvalid   = (rd_state == R_ADDR);
    m_arready = '0;
    m_rvalid  = '0;
    rready    = 1'b0;
    m_rdata   = rdata;
    m_rlast   = rlast;
    if (rd_state == R_ADDR && arready) m_arready[rd_grant] = 1'b1;
    if (rd_state == R_DATA) begin
      m_rvalid[rd_grant] = rvalid;
      rready             = m_rready[rd_grant];
    end
  end

  // Write-side outputs; the W channel is a live pass-through of the grantee.
  always_comb begin
    awid      = 4'(wr_grant);
    awaddr    = wr_addr_q;
    awlen     = wr_len_q;
    awsize    = wr_size_q;
    awburst   = 2'b01;
    awlock    = 2'b00;
    awcache   = 4'b0000;
    awprot    = 3'b000;
    awvalid   = (wr_state == W_ADDR);
    wid       = 4'(wr_grant);
    wdata     = w_data_a[wr_grant];
    wstrb     = w_strb_a[wr_grant];
    wlast     = m_wlast[wr_grant];
    wvalid    = 1'b0;
    bready    = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    if (wr_state == W_ADDR && awready) m_awready[wr_grant] = 1'b1;
    if (wr_state == W_DATA) begin
      wvalid             = m_wvalid[wr_grant];
      m_wready[wr_grant] = wready;
    end
    if (wr_state == W_RESP) begin
      m_bvalid[wr_grant] = bvalid;
      bready             = m_bready[wr_grant];
    end
  end

  // Response IDs and status codes are intentionally not interpreted.
  logic unused_ok;
  assign unused_ok = ^{rid, rresp, bid, bresp};

endmodule

// File: tb/tb_axi_rr_arbiter.sv
module tb_axi_rr_arbiter;
  localparam int N = 3;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  // ---------------- DUT signals ----------------
  logic [N*32-1:0] m_araddr, m_awaddr, m_wdata;
  logic [N*8-1:0]  m_arlen, m_awlen;
  logic [N*3-1:0]  m_arsize, m_awsize;
  logic [N*4-1:0]  m_wstrb;
  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N-1:0]    m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0]     m_rdata;
  logic            m_rlast;
  logic [3:0]      arid, awid, wid, rid, bid;
  logic [31:0]     araddr, awaddr, wdata, rdata;
  logic [7:0]      arlen, awlen;
  logic [2:0]      arsize, awsize, arprot, awprot;
  logic [1:0]      arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]      arcache, awcache, wstrb;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  axi_rr_arbiter #(.NUM_MST(N), .LINE_W(5)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [43:0] ar_exp_q[$];  // {id, addr, len}
  logic [43:0] aw_exp_q[$];  // {id, addr, len}
  logic [35:0] r_exp_q[$];   // {owner, data, last}
  logic [40:0] w_exp_q[$];   // {id, data, strb, last}
  logic [3:0]  b_exp_q[$];   // owner
  int          r_beats_seen = 0;
  logic        overlap = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_read(input int m, input logic [31:0] addr, input int len);
    ar_exp_q.push_back({4'(m), addr, 8'(len)});
    for (int b = 0; b <= len; b++)
      r_exp_q.push_back({3'(m), addr + 32'(4 * b), (b == len)});
  endtask

  task automatic exp_write(input int m, input logic [31:0] addr, input int len,
                           input logic [31:0] base);
    aw_exp_q.push_back({4'(m), addr, 8'(len)});
    for (int b = 0; b <= len; b++)
      w_exp_q.push_back({4'(m), base + 32'(b), 4'hF, (b == len)});
    b_exp_q.push_back(4'(m));
  endtask

  function automatic int pending();
    return ar_exp_q.size() + aw_exp_q.size() + r_exp_q.size() + w_exp_q.size() + b_exp_q.size();
  endfunction

  // ---------------- master drivers ----------------
  int          ar_more [N];
  int          wbeat [N];
  int          wlen [N];
  logic [31:0] wbase [N];
  logic        rr_toggle = 1'b0;

  task automatic drive_read(input int m, input logic [31:0] addr, input int len, input int more);
    ar_more[m] = more;
    m_araddr[m*32 +: 32] = addr;
    m_arlen[m*8 +: 8]    = 8'(len);
    m_arsize[m*3 +: 3]   = 3'd2;
    m_arvalid[m]         = 1'b1;
  endtask

  task automatic drive_write(input int m, input logic [31:0] addr, input int len,
                             input logic [31:0] base);
    m_awaddr[m*32 +: 32] = addr;
    m_awlen[m*8 +: 8]    = 8'(len);
    m_awsize[m*3 +: 3]   = 3'd2;
    m_awvalid[m]         = 1'b1;
    wbeat[m] = 0;
    wlen[m]  = len;
    wbase[m] = base;
    m_wdata[m*32 +: 32]  = base;
    m_wstrb[m*4 +: 4]    = 4'hF;
    m_wlast[m]           = (len == 0);
    m_wvalid[m]          = 1'b1;
  endtask

  // Master-side handshake follow-up: drop or advance after each transfer.
  initial begin
    logic [N-1:0] ar_acc, aw_acc, w_acc;
    forever begin
      @(negedge aclk);
      ar_acc = m_arvalid & m_arready;
      aw_acc = m_awvalid & m_awready;
      w_acc  = m_wvalid & m_wready;
      @(posedge aclk);
      #1;
      if (aresetn) begin
        for (int m = 0; m < N; m++) begin
          if (ar_acc[m]) begin
            if (ar_more[m] > 0) begin
              ar_more[m]--;
              m_araddr[m*32 +: 32] = m_araddr[m*32 +: 32] + 32'h100;
            end else begin
              m_arvalid[m] = 1'b0;
            end
          end
          if (aw_acc[m]) m_awvalid[m] = 1'b0;
          if (w_acc[m]) begin
            if (wbeat[m] == wlen[m]) begin
              m_wvalid[m] = 1'b0;
            end else begin
              wbeat[m]++;
              m_wdata[m*32 +: 32] = wbase[m] + 32'(wbeat[m]);
              m_wlast[m] = (wbeat[m] == wlen[m]);
            end
          end
        end
        if (rr_toggle) m_rready[1] = ~m_rready[1];
      end
    end
  end

  // ---------------- AXI3 slave model ----------------
  logic        w_stall = 1'b0;
  logic        r_active = 1'b0;
  logic [31:0] r_addr;
  int          r_beat, r_len;

  initial begin
    logic ar_hs, r_hs, w_hs, w_l, b_hs;
    logic [31:0] s_addr;
    logic [7:0]  s_len;
    logic [3:0]  s_id;
    forever begin
      @(negedge aclk);
      ar_hs = arvalid & arready;
      r_hs  = rvalid & rready;
      w_hs  = wvalid & wready;
      w_l   = wlast;
      b_hs  = bvalid & bready;
      s_addr = araddr;
      s_len  = arlen;
      s_id   = arid;
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        r_active = 1'b0;
        rvalid   = 1'b0;
        rlast    = 1'b0;
        bvalid   = 1'b0;
      end else begin
        if (r_hs) begin
          if (r_beat == r_len) r_active = 1'b0;
          else r_beat++;
        end
        if (ar_hs) begin
          r_active = 1'b1;
          r_addr   = s_addr;
          r_len    = int'(s_len);
          r_beat   = 0;
          rid      = s_id;
        end
        rvalid = r_active;
        rdata  = r_addr + 32'(4 * r_beat);
        rlast  = r_active && (r_beat == r_len);
        if (b_hs) bvalid = 1'b0;
        if (w_hs && w_l) bvalid = 1'b1;
        wready = !w_stall;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [43:0]  ea;
    logic [35:0]  er;
    logic [40:0]  ew;
    logic [3:0]   eb;
    logic [N-1:0] one;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (arvalid && awvalid) overlap = 1'b1;
        if (arvalid && arready) begin
          if (ar_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL ar_unexpected: got addr %0h expected no request", araddr);
          end else begin
            ea = ar_exp_q.pop_front();
            check("ar_req", {20'd0, arid, araddr, arlen}, {20'd0, ea});
            check("ar_fixed", {53'd0, arburst, arlock, arcache, arprot}, {53'd0, 2'b01, 2'b00, 4'h0, 3'h0});
            one = '0;
            one[ea[43:40]] = 1'b1;
            check("m_arready_pulse", {61'd0, m_arready}, {61'd0, one});
          end
        end
        if (awvalid && awready) begin
          if (aw_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL aw_unexpected: got addr %0h expected no request", awaddr);
          end else begin
            ea = aw_exp_q.pop_front();
            check("aw_req", {20'd0, awid, awaddr, awlen}, {20'd0, ea});
            check("aw_fixed", {53'd0, awburst, awlock, awcache, awprot}, {53'd0, 2'b01, 2'b00, 4'h0, 3'h0});
            one = '0;
            one[ea[43:40]] = 1'b1;
            check("m_awready_pulse", {61'd0, m_awready}, {61'd0, one});
          end
        end
        if (rvalid && r_exp_q.size() != 0) begin
          one = '0;
          one[r_exp_q[0][35:33]] = 1'b1;
          check("m_rvalid_route", {61'd0, m_rvalid}, {61'd0, one});
        end
        for (int m = 0; m < N; m++) begin
          if (m_rvalid[m] && m_rready[m]) begin
            r_beats_seen++;
            if (r_exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL r_unexpected: got beat %0h to master %0d expected none", m_rdata, m);
            end else begin
              er = r_exp_q.pop_front();
              check("r_beat", {28'd0, 3'(m), m_rdata, m_rlast}, {28'd0, er});
            end
          end
        end
        if (wvalid && wready) begin
          if (w_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL w_unexpected: got data %0h expected none", wdata);
          end else begin
            ew = w_exp_q.pop_front();
            check("w_beat", {23'd0, wid, wdata, wstrb, wlast}, {23'd0, ew});
          end
        end
        for (int m = 0; m < N; m++) begin
          if (m_bvalid[m] && m_bready[m]) begin
            if (b_exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL b_unexpected: got response to master %0d expected none", m);
            end else begin
              eb = b_exp_q.pop_front();
              check("b_resp", 64'(m), {60'd0, eb});
            end
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (pending() != 0 && n < budget) begin
      @(posedge aclk);
      n++;
    end
    checks++;
    if (pending() != 0) begin
      errors++;
      $display("FAIL %s: got %0d items pending after %0d cycles expected 0", name, pending(), budget);
    end
    @(posedge aclk);
    #1;
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    int base;
    int n;
    aresetn   = 1'b0;
    m_araddr  = '0; m_arlen = '0; m_arsize = '0; m_arvalid = '0;
    m_awaddr  = '0; m_awlen = '0; m_awsize = '0; m_awvalid = '0;
    m_wdata   = '0; m_wstrb = '0; m_wlast = '0; m_wvalid = '0;
    m_rready  = '1; m_bready = '1;
    arready   = 1'b1; awready = 1'b1; wready = 1'b1;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    bid = '0; bresp = '0; bvalid = 1'b0;
    for (int m = 0; m < N; m++) begin
      ar_more[m] = 0; wbeat[m] = 0; wlen[m] = 0; wbase[m] = '0;
    end

    repeat (3) @(posedge aclk);
    #1;
    check("rst_axi_valid_ready", {59'd0, arvalid, awvalid, wvalid, rready, bready}, 64'd0);
    check("rst_m_ready", {55'd0, m_arready, m_awready, m_wready}, 64'd0);
    check("rst_m_valid", {58'd0, m_rvalid, m_bvalid}, 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Round-robin order with all masters requesting; master 0 asks twice.
    exp_read(0, 32'h0000_1000, 3);
    exp_read(1, 32'h0000_2000, 3);
    exp_read(2, 32'h0000_3000, 3);
    exp_read(0, 32'h0000_1100, 3);
    drive_read(0, 32'h0000_1000, 3, 1);
    drive_read(1, 32'h0000_2000, 3, 0);
    drive_read(2, 32'h0000_3000, 3, 0);
    wait_drain("scn_rr_order", 400);

    // Master 1 read with its rready toggling every cycle.
    base = r_beats_seen;
    rr_toggle = 1'b1;
    exp_read(1, 32'h0000_2200, 3);
    drive_read(1, 32'h0000_2200, 3, 0);
    wait_drain("scn_rready_toggle", 200);
    rr_toggle = 1'b0;
    m_rready  = '1;
    check("scn_rready_toggle_beats", 64'(r_beats_seen - base), 64'd4);

    // Concurrent read (master 0) and write (master 2).
    overlap = 1'b0;
    exp_read(0, 32'h0000_4000, 1);
    exp_write(2, 32'h0000_5000, 1, 32'h0000_A000);
    drive_read(0, 32'h0000_4000, 1, 0);
    drive_write(2, 32'h0000_5000, 1, 32'h0000_A000);
    wait_drain("scn_rd_wr_concurrent", 200);
    check("scn_ar_aw_overlap", {63'd0, overlap}, 64'd1);

    // Two simultaneous writes: pointer at master 2, so 0 then 1.
    exp_write(0, 32'h0000_6000, 0, 32'h0000_B000);
    exp_write(1, 32'h0000_7000, 2, 32'h0000_C000);
    drive_write(0, 32'h0000_6000, 0, 32'h0000_B000);
    drive_write(1, 32'h0000_7000, 2, 32'h0000_C000);
    wait_drain("scn_wr_rr", 200);

    // Reset during the second beat of a master 1 read.
    base = r_beats_seen;
    exp_read(1, 32'h0000_8000, 3);
    drive_read(1, 32'h0000_8000, 3, 0);
    n = 0;
    while (r_beats_seen < base + 1 && n < 100) begin
      @(posedge aclk);
      n++;
    end
    check("scn_reset_reached_beat2", {63'd0, (r_beats_seen >= base + 1)}, 64'd1);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("rst_mid_arvalid_rready", {62'd0, arvalid, rready}, 64'd0);
    check("rst_mid_m_rvalid", {61'd0, m_rvalid}, 64'd0);
    m_arvalid = '0;
    m_awvalid = '0;
    m_wvalid  = '0;
    r_exp_q.delete();
    ar_exp_q.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    exp_read(0, 32'h0000_9000, 0);
    exp_read(1, 32'h0000_9100, 0);
    drive_read(0, 32'h0000_9000, 0, 0);
    drive_read(1, 32'h0000_9100, 0, 0);
    wait_drain("scn_after_reset", 200);

`ifdef ARB_RAW_GUARD_EN
    // Same-line read held behind an in-flight write; other-line read proceeds.
    w_stall = 1'b1;
    exp_write(2, 32'h1FC0_0020, 3, 32'h0000_D000);
    drive_write(2, 32'h1FC0_0020, 3, 32'h0000_D000);
    repeat (4) @(posedge aclk);
    #1;
    exp_read(1, 32'h1FC0_0040, 0);
    exp_read(0, 32'h1FC0_0034, 0);
    drive_read(0, 32'h1FC0_0034, 0, 0);
    drive_read(1, 32'h1FC0_0040, 0, 0);
    repeat (10) @(posedge aclk);
    #1;
    check("raw_read_held", {63'd0, m_arvalid[0]}, 64'd1);
    w_stall = 1'b0;
    wait_drain("scn_raw_guard", 200);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected sequence completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
